// File: rtl/gat_pkg.sv
// Shared GAT pipeline constants and the coefficient-packer FSM state type.
package gat_pkg;

    localparam int unsigned DATA_WIDTH     = 8;
    localparam int unsigned MAX_NODES      = 168;
    localparam int unsigned NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int unsigned SOFTMAX_WIDTH  = MAX_NODES * DATA_WIDTH + NUM_NODE_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StEmit
    } coef_pack_state_t;

endpackage

// File: rtl/coef_packer.sv
// Drains the per-edge coefficient FIFO and packs each subgraph's coefficients,
// plus their sum and node count, into one word for the softmax stage.
module coef_packer #(
    parameter int unsigned DATA_WIDTH     = gat_pkg::DATA_WIDTH,
    parameter int unsigned MAX_NODES      = gat_pkg::MAX_NODES,
    parameter int unsigned NUM_NODE_WIDTH = $clog2(MAX_NODES),
    parameter int unsigned SOFTMAX_WIDTH  = MAX_NODES * DATA_WIDTH + NUM_NODE_WIDTH,
    parameter int unsigned SUM_WIDTH      = DATA_WIDTH + NUM_NODE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     coef_ff_dout,
    input  logic                      coef_ff_empty,
    output logic                      coef_ff_rd_vld,
    input  logic [NUM_NODE_WIDTH-1:0] num_node_ff_dout,
    input  logic                      num_node_ff_empty,
    output logic                      num_node_ff_rd_vld,
    output logic [SOFTMAX_WIDTH-1:0]  sm_data_o,
    output logic [SUM_WIDTH-1:0]      sm_sum_o,
    output logic                      sm_vld_o,
    input  logic                      sm_rdy_i,
    output logic                      ovf_err_o
);

    import gat_pkg::*;

    coef_pack_state_t state_q, state_d;

    logic [NUM_NODE_WIDTH-1:0] n_q;
    logic [NUM_NODE_WIDTH-1:0] idx_q;
    logic [NUM_NODE_WIDTH-1:0] n_clamped;
    logic [SUM_WIDTH-1:0]      sum_q;
    logic [DATA_WIDTH-1:0]     slot_q [MAX_NODES];
    logic                      ovf_q;
    logic                      raw_over;
    logic                      last_coef;
    logic                      nn_pop;
    logic                      coef_pop;

    // Counts above MAX_NODES are clamped; the excess coefficients stay queued.
    always_comb begin
        raw_over  = 32'(num_node_ff_dout) > MAX_NODES;
        n_clamped = raw_over ? NUM_NODE_WIDTH'(MAX_NODES) : num_node_ff_dout;
        last_coef = (idx_q == n_q - NUM_NODE_WIDTH'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (nn_pop) begin
                    state_d = (n_clamped == '0) ? StEmit : StCollect;
                end
            end
            StCollect: begin
                if (coef_pop && last_coef) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (sm_rdy_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; pops are suppressed in a reset cycle.
    always_comb begin
        num_node_ff_rd_vld = (state_q == StIdle) && !num_node_ff_empty && !rst;
        coef_ff_rd_vld     = (state_q == StCollect) && !coef_ff_empty && !rst;
        sm_vld_o           = (state_q == StEmit);
        nn_pop             = num_node_ff_rd_vld;
        coef_pop           = coef_ff_rd_vld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            idx_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (nn_pop) begin
            n_q   <= n_clamped;
            idx_q <= '0;
            sum_q <= '0;
            if (raw_over) begin
                ovf_q <= 1'b1;
            end
        end else if (coef_pop) begin
            idx_q <= idx_q + NUM_NODE_WIDTH'(1);
            sum_q <= sum_q + SUM_WIDTH'(coef_ff_dout);
        end
    end

    // Slot buffer: cleared at the start of every subgraph so slots >= n read as zero.
    always_ff @(posedge clk) begin
        if (rst || nn_pop) begin
            for (int unsigned k = 0; k < MAX_NODES; k++) begin
                slot_q[k] <= '0;
            end
        end else if (coef_pop) begin
            for (int unsigned k = 0; k < MAX_NODES; k++) begin
                if (idx_q == NUM_NODE_WIDTH'(k)) begin
                    slot_q[k] <= coef_ff_dout;
                end
            end
        end
    end

    always_comb begin
        sm_data_o = '0;
        sm_data_o[NUM_NODE_WIDTH-1:0] = n_q;
        for (int unsigned k = 0; k < MAX_NODES; k++) begin
            sm_data_o[NUM_NODE_WIDTH + k * DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
        end
    end

    assign sm_sum_o  = sum_q;
    assign ovf_err_o = ovf_q;

endmodule

// File: tb/tb_coef_packer.sv
// Scoreboard bench for coef_packer with MAX_NODES=4 and a 3-bit node count.
module tb_coef_packer;

    localparam int DW  = 8;
    localparam int MN  = 4;
    localparam int NNW = 3;
    localparam int SMW = MN * DW + NNW;
    localparam int SW  = DW + NNW;

    typedef struct packed {
        logic [SMW-1:0] data;
        logic [SW-1:0]  sum;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  coef_ff_dout;
    logic           coef_ff_empty;
    logic           coef_ff_rd_vld;
    logic [NNW-1:0] num_node_ff_dout;
    logic           num_node_ff_empty;
    logic           num_node_ff_rd_vld;
    logic [SMW-1:0] sm_data_o;
    logic [SW-1:0]  sm_sum_o;
    logic           sm_vld_o;
    logic           sm_rdy_i;
    logic           ovf_err_o;

    exp_t           exp_q[$];
    logic [DW-1:0]  coef_fifo[$];
    logic [NNW-1:0] nn_fifo[$];
    int             hs_cyc[$];
    int             nn_pop_cyc[$];
    int tests = 0, fails = 0, cyc = 0;
    int coef_pops = 0, nn_pops = 0, vld_cycles = 0;

    always #5 clk = ~clk;

    coef_packer #(
        .DATA_WIDTH    (DW),
        .MAX_NODES     (MN),
        .NUM_NODE_WIDTH(NNW),
        .SOFTMAX_WIDTH (SMW),
        .SUM_WIDTH     (SW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .coef_ff_dout      (coef_ff_dout),
        .coef_ff_empty     (coef_ff_empty),
        .coef_ff_rd_vld    (coef_ff_rd_vld),
        .num_node_ff_dout  (num_node_ff_dout),
        .num_node_ff_empty (num_node_ff_empty),
        .num_node_ff_rd_vld(num_node_ff_rd_vld),
        .sm_data_o         (sm_data_o),
        .sm_sum_o          (sm_sum_o),
        .sm_vld_o          (sm_vld_o),
        .sm_rdy_i          (sm_rdy_i),
        .ovf_err_o         (ovf_err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [SMW-1:0] d, input logic [SW-1:0] s);
        exp_t e;
        e.data = d;
        e.sum  = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_coef_empty(input string name, input int budget);
        int k = 0;
        while (coef_fifo.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        check({"coef_drained_", name}, 64'(coef_fifo.size()), 64'd0);
    endtask

    // FWFT FIFO models: pops sampled mid-cycle, applied just after the edge.
    initial begin
        logic cp, np;
        coef_ff_empty = 1'b1; coef_ff_dout = '0;
        num_node_ff_empty = 1'b1; num_node_ff_dout = '0;
        forever begin
            @(negedge clk);
            cp = coef_ff_rd_vld;
            np = num_node_ff_rd_vld;
            if (np) nn_pop_cyc.push_back(cyc);
            @(posedge clk);
            cyc++;
            #1;
            if (cp) begin
                coef_pops++;
                if (coef_fifo.size() > 0) void'(coef_fifo.pop_front());
            end
            if (np) begin
                nn_pops++;
                if (nn_fifo.size() > 0) void'(nn_fifo.pop_front());
            end
            #2;
            coef_ff_empty     = (coef_fifo.size() == 0);
            coef_ff_dout      = coef_ff_empty ? '0 : coef_fifo[0];
            num_node_ff_empty = (nn_fifo.size() == 0);
            num_node_ff_dout  = num_node_ff_empty ? '0 : nn_fifo[0];
        end
    end

    // Monitor: compares every accepted word against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sm_vld_o) begin
                vld_cycles++;
                check("no_pop_in_emit", 64'({coef_ff_rd_vld, num_node_ff_rd_vld}), 64'd0);
                if (sm_rdy_i) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got 0x%0h, expected none", sm_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", 64'(sm_data_o), 64'(e.data));
                        check("word_sum", 64'(sm_sum_o), 64'(e.sum));
                    end
                end else if (exp_q.size() > 0) begin
                    check("hold_data", 64'(sm_data_o), 64'(exp_q[0].data));
                    check("hold_sum", 64'(sm_sum_o), 64'(exp_q[0].sum));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, n0, v0;
        rst = 1'b1;
        sm_rdy_i = 1'b1;

        // Basic pack, two back-to-back subgraphs queued during reset
        nn_fifo.push_back(3'd3);
        coef_fifo.push_back(8'h05); coef_fifo.push_back(8'h10); coef_fifo.push_back(8'h7F);
        nn_fifo.push_back(3'd3);
        coef_fifo.push_back(8'h01); coef_fifo.push_back(8'h02); coef_fifo.push_back(8'h03);
        push_exp({8'h00, 8'h7F, 8'h10, 8'h05, 3'd3}, 11'h094);
        push_exp({8'h00, 8'h03, 8'h02, 8'h01, 3'd3}, 11'h006);
        step(3);
        check("rst_vld", 64'(sm_vld_o), 64'd0);
        check("rst_data", 64'(sm_data_o), 64'd0);
        check("rst_sum", 64'(sm_sum_o), 64'd0);
        check("rst_coef_rd", 64'(coef_ff_rd_vld), 64'd0);
        check("rst_nn_rd", 64'(num_node_ff_rd_vld), 64'd0);
        check("rst_ovf", 64'(ovf_err_o), 64'd0);
        v0 = vld_cycles;
        hs_cyc.delete();
        rst = 1'b0;
        wait_drain("basic", 50);
        check("basic_vld_cycles", 64'(vld_cycles - v0), 64'd2);
        check("basic_hs_count", 64'(hs_cyc.size()), 64'd2);
        if (hs_cyc.size() == 2) check("basic_period", 64'(hs_cyc[1] - hs_cyc[0]), 64'd5);

        // Zero nodes: a waiting coefficient must not be popped
        c0 = coef_pops;
        nn_fifo.push_back(3'd0);
        coef_fifo.push_back(8'h55);
        push_exp('0, '0);
        wait_drain("zero", 20);
        step(2);
        check("zero_no_coef_pop", 64'(coef_pops - c0), 64'd0);

        // Stall: second coefficient arrives 4 cycles late
        c0 = coef_pops;
        v0 = vld_cycles;
        nn_fifo.push_back(3'd2);
        push_exp({8'h00, 8'h00, 8'h21, 8'h55, 3'd2}, 11'h076);
        wait_coef_empty("stall", 20);
        n0 = coef_pops;
        step(4);
        check("stall_no_pop", 64'(coef_pops - n0), 64'd0);
        check("stall_no_word", 64'(vld_cycles - v0), 64'd0);
        coef_fifo.push_back(8'h21);
        wait_drain("stall", 20);
        check("stall_pops", 64'(coef_pops - c0), 64'd2);

        // Backpressure: 6 extra cycles with ready low, next subgraph waiting
        sm_rdy_i = 1'b0;
        hs_cyc.delete();
        nn_pop_cyc.delete();
        nn_fifo.push_back(3'd1); coef_fifo.push_back(8'h80);
        nn_fifo.push_back(3'd1); coef_fifo.push_back(8'h01);
        push_exp({8'h00, 8'h00, 8'h00, 8'h80, 3'd1}, 11'h080);
        push_exp({8'h00, 8'h00, 8'h00, 8'h01, 3'd1}, 11'h001);
        begin
            int k = 0;
            while (!sm_vld_o && k < 20) begin
                step(1);
                k++;
            end
        end
        check("bp_vld_seen", 64'(sm_vld_o), 64'd1);
        c0 = coef_pops;
        n0 = nn_pops;
        step(6);
        check("bp_no_coef_pop", 64'(coef_pops - c0), 64'd0);
        check("bp_no_nn_pop", 64'(nn_pops - n0), 64'd0);
        check("bp_vld_held", 64'(sm_vld_o), 64'd1);
        sm_rdy_i = 1'b1;
        wait_drain("bp", 20);
        check("bp_hs_count", 64'(hs_cyc.size()), 64'd2);
        if (hs_cyc.size() == 2 && nn_pop_cyc.size() == 2) begin
            check("bp_next_start", 64'(nn_pop_cyc[1]), 64'(hs_cyc[0] + 1));
            check("bp_second_period", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
        end

        // Overflow: count 6 clamps to 4 and the flag stays set
        check("ovf_before", 64'(ovf_err_o), 64'd0);
        nn_fifo.push_back(3'd6);
        coef_fifo.push_back(8'h11); coef_fifo.push_back(8'h22);
        coef_fifo.push_back(8'h33); coef_fifo.push_back(8'h44);
        push_exp({8'h44, 8'h33, 8'h22, 8'h11, 3'd4}, 11'h0AA);
        nn_fifo.push_back(3'd1); coef_fifo.push_back(8'h02);
        push_exp({8'h00, 8'h00, 8'h00, 8'h02, 3'd1}, 11'h002);
        step(2);
        check("ovf_set", 64'(ovf_err_o), 64'd1);
        wait_drain("ovf", 30);
        check("ovf_sticky", 64'(ovf_err_o), 64'd1);

        // Reset after 2 of 4 coefficients, then a clean subgraph
        nn_fifo.push_back(3'd4);
        coef_fifo.push_back(8'hAA); coef_fifo.push_back(8'hBB);
        wait_coef_empty("midrst", 20);
        step(1);
        rst = 1'b1;
        nn_fifo.push_back(3'd2);
        coef_fifo.push_back(8'h03); coef_fifo.push_back(8'h04);
        push_exp({8'h00, 8'h00, 8'h04, 8'h03, 3'd2}, 11'h007);
        c0 = coef_pops;
        step(2);
        check("rst2_nn_rd", 64'(num_node_ff_rd_vld), 64'd0);
        check("rst2_coef_rd", 64'(coef_ff_rd_vld), 64'd0);
        check("rst2_vld", 64'(sm_vld_o), 64'd0);
        check("rst2_data", 64'(sm_data_o), 64'd0);
        check("rst2_sum", 64'(sm_sum_o), 64'd0);
        check("rst2_ovf", 64'(ovf_err_o), 64'd0);
        check("rst2_no_pop", 64'(coef_pops - c0), 64'd0);
        rst = 1'b0;
        wait_drain("after_rst", 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coef_packer.md
# coef_packer

Downstream neighbour of the attention-coefficient DMVM stage. It drains the per-edge coefficient FIFO that DMVM writes, one byte per cycle. It groups the coefficients of each subgraph, using that subgraph's node count from the num-node FIFO, into one packed softmax word. It presents the word, with the subgraph coefficient sum, to the softmax stage over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 8, coefficient width (unsigned, already ReLU-clamped by DMVM)
- `MAX_NODES`, 168, maximum nodes per subgraph
- `NUM_NODE_WIDTH`, `$clog2(MAX_NODES)`, node-count width
- `SOFTMAX_WIDTH`, `MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH`, packed output width
- `SUM_WIDTH`, `DATA_WIDTH+NUM_NODE_WIDTH`, coefficient-sum width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous and active-high (fixed)
- `coef_ff_dout`  in  DATA_WIDTH  coefficient FIFO head (first-word-fall-through)
- `coef_ff_empty`  in  1  coefficient FIFO empty
- `coef_ff_rd_vld`  out  1  pop coefficient FIFO this cycle
- `num_node_ff_dout`  in  NUM_NODE_WIDTH  node count of next subgraph (FWFT)
- `num_node_ff_empty`  in  1  num-node FIFO empty
- `num_node_ff_rd_vld`  out  1  pop num-node FIFO this cycle
- `sm_data_o`  out  SOFTMAX_WIDTH  packed word: slot k at `[NUM_NODE_WIDTH+k*DATA_WIDTH +: DATA_WIDTH]`, node count at `[NUM_NODE_WIDTH-1:0]`
- `sm_sum_o`  out  SUM_WIDTH  unsigned sum of the packed coefficients
- `sm_vld_o`  out  1  packed word valid
- `sm_rdy_i`  in  1  softmax stage accepts the word
- `ovf_err_o`  out  1  sticky: node count above MAX_NODES was received

## Operation
- FSM states: IDLE, COLLECT, EMIT.
- **IDLE**
  - With `num_node_ff_empty`=0: assert `num_node_ff_rd_vld` for one cycle.
  - Latch count n = min(`num_node_ff_dout`, MAX_NODES). If the raw value exceeds MAX_NODES, set `ovf_err_o`.
  - Clear the slot buffer and sum; set slot index to 0.
  - Next state: COLLECT if n>0; EMIT if n==0, which yields an all-zero word with count 0.
- **COLLECT**
  - `coef_ff_rd_vld` = !`coef_ff_empty`, combinational, one pop per cycle.
  - On each pop: slot[idx] <= `coef_ff_dout`; sum += `coef_ff_dout`, zero-extended; idx++.
  - On the pop where idx==n-1: go to EMIT.
  - Empty FIFO: stall in COLLECT and keep state.
- **EMIT**
  - `sm_vld_o`=1 with `sm_data_o`, `sm_sum_o` and the count field stable until `sm_rdy_i`=1.
  - On the handshake cycle: go to IDLE.
  - No FIFO pops in EMIT.
- Slots at index ≥ n are zero.
- The sum cannot overflow: SUM_WIDTH covers MAX_NODES*(2^DATA_WIDTH−1).
- `num_node_ff_rd_vld` is only asserted in IDLE and `coef_ff_rd_vld` only in COLLECT, so the two are never high together.
- **Excess coefficients:** coefficients beyond a clamped n stay in the FIFO. They are read as the next subgraph's data. This is a system error flagged by `ovf_err_o`; no recovery is attempted.
- **Reset:** `rst` at any cycle discards the partial subgraph and returns to IDLE. No pop is asserted in a reset cycle.

## Timing
- Values after reset: state IDLE; `sm_vld_o`=0; `sm_data_o`=0; `sm_sum_o`=0; `coef_ff_rd_vld`=0; `num_node_ff_rd_vld`=0; `ovf_err_o`=0.
- `sm_data_o` and `sm_sum_o` are registered. `sm_vld_o` is decoded from state. Pop strobes are combinational from state and the FIFO empty flags.
- Per subgraph with FIFOs never empty: 1 cycle in IDLE + n cycles in COLLECT + ≥1 cycle in EMIT. `sm_vld_o` rises 1 cycle after the last coefficient pop.
- Back-to-back throughput is n+2 cycles per subgraph when `sm_rdy_i` is tied high.
- Backpressure: while `sm_vld_o`=1 and `sm_rdy_i`=0, no FIFO is popped. Upstream DMVM stalls through `coef_ff_full`.

## Structure
- Shared package `gat_pkg` holds `DATA_WIDTH`, `MAX_NODES`, `NUM_NODE_WIDTH`, `SOFTMAX_WIDTH` and the FSM state enum `coef_pack_state_t`.
- The slot buffer is an array of `MAX_NODES` × `DATA_WIDTH` registers with an indexed write enable.
- No sub-module is needed. The optional sub-module `coef_slot_buffer` (indexed write, synchronous clear) is allowed if it helps synthesis fan-out.

## Test plan
Bench parameters: MAX_NODES=4, DATA_WIDTH=8, NUM_NODE_WIDTH=2 (n=4 saturates; use NUM_NODE_WIDTH=3 for the overflow case).
- **Basic pack:** node count 3, coefficients 0x05, 0x10, 0x7F, `sm_rdy_i`=1 → one word, slots {0x05, 0x10, 0x7F, 0x00}, count 3, `sm_sum_o`=0x94, `sm_vld_o` high exactly 1 cycle, 5 cycles per subgraph.
- **Zero nodes:** node count 0 → all-zero word, count 0, sum 0; no coefficient pop occurs.
- **Stall:** node count 2; coef FIFO empty for 4 cycles between the two coefficients → no spurious pop; correct word when the second coefficient arrives.
- **Backpressure:** `sm_rdy_i`=0 for 6 cycles during EMIT → outputs stable, zero pops; next subgraph starts the cycle after the handshake.
- **Overflow:** node count 6 with NUM_NODE_WIDTH=3 → count clamped to 4, `ovf_err_o`=1 and sticky until `rst`.
- **Reset mid-collect:** `rst` after 2 of 4 coefficients → outputs return to reset values; a following subgraph packs correctly with no stale slots.
